// File: rtl/race_pkg.sv
// Shared definitions for the race-timing subsystem: state encodings,
// the {red, yellow, green} lamp vector and default timer sizing.
package race_pkg;

  // Default reaction counter width and timeout (cycles after green).
  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 200;

  // State encodings for the reaction timer FSM.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_TIMING = 3'd2;
  localparam logic [2:0] ST_OK     = 3'd3;
  localparam logic [2:0] ST_FALSE  = 3'd4;
  localparam logic [2:0] ST_TMO    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_ARMED  = ST_ARMED,
    S_TIMING = ST_TIMING,
    S_OK     = ST_OK,
    S_FALSE  = ST_FALSE,
    S_TMO    = ST_TMO
  } state_t;

  // Lamp vector as driven by the light controller: {red, yellow, green}.
  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_DARK   = 3'b000;
  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;

endpackage

// File: rtl/race_reaction_timer_if.sv
// Lamp/pedal inputs and result outputs of the reaction timer.
// master = light controller / driver side, slave = reaction timer.
interface race_reaction_timer_if #(
  parameter int CNT_W = 8
);
  logic             red;
  logic             yellow;
  logic             green;
  logic             go;
  logic             busy;
  logic             valid;
  logic             false_start;
  logic             timeout;
  logic [CNT_W-1:0] reaction_time;
  logic [CNT_W-1:0] best_time;

  modport master (
    output red, yellow, green, go,
    input  busy, valid, false_start, timeout, reaction_time, best_time
  );

  modport slave (
    input  red, yellow, green, go,
    output busy, valid, false_start, timeout, reaction_time, best_time
  );
endinterface

// File: rtl/race_reaction_counter.sv
// Reaction counter: loads to 1 on green onset, counts while enabled and
// saturates at TIMEOUT, where terminal_o is raised.
module race_reaction_counter
  import race_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             terminal_o
);

  localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_VAL  = CNT_W'(1);

  logic [CNT_W-1:0] count_q;

  // Load has priority; the count holds once it reaches TIMEOUT so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= ONE_VAL;
    end else if (en_i && (count_q != TERM_VAL)) begin
      count_q <= count_q + ONE_VAL;
    end
  end

  assign count_o    = count_q;
  assign terminal_o = (count_q == TERM_VAL);

endmodule

// File: rtl/race_reaction_timer.sv
// Race reaction timer: judges each start as valid launch, false start or
// timeout and measures reaction time in cycles from green onset.
// Optional feature macro: RACE_BEST_TIME_EN (best valid reaction since reset).
module race_reaction_timer
  import race_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  race_reaction_timer_if.slave  bus
);

  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);

  state_t           state_q;
  logic             busy_q;
  logic             valid_q;
  logic             falseStart_q;
  logic             timeout_q;
  logic [CNT_W-1:0] reactionTime_q;

  logic             cntLoad_d;
  logic             cntEn_d;
  logic [CNT_W-1:0] cntValue;
  logic             cntTerminal;

  // Counter control: load on the green edge in ARMED, count in TIMING until go.
  always_comb begin
    cntLoad_d = (state_q == S_ARMED) && bus.green && !bus.go;
    cntEn_d   = (state_q == S_TIMING) && !bus.go;
  end

  race_reaction_counter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cntLoad_d),
    .en_i       (cntEn_d),
    .count_o    (cntValue),
    .terminal_o (cntTerminal)
  );

  // Race FSM with registered busy, result flags and latched reaction time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      busy_q         <= 1'b0;
      valid_q        <= 1'b0;
      falseStart_q   <= 1'b0;
      timeout_q      <= 1'b0;
      reactionTime_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.yellow) begin
            state_q <= S_ARMED;
            busy_q  <= 1'b1;
          end
        end
        S_ARMED: begin
          if (bus.go && !bus.green) begin
            state_q        <= S_FALSE;
            busy_q         <= 1'b0;
            falseStart_q   <= 1'b1;
            reactionTime_q <= '0;
          end else if (bus.green && bus.go) begin
            state_q        <= S_OK;
            busy_q         <= 1'b0;
            valid_q        <= 1'b1;
            reactionTime_q <= '0;
          end else if (bus.green) begin
            state_q <= S_TIMING;
          end
        end
        S_TIMING: begin
          if (bus.go) begin
            state_q        <= S_OK;
            busy_q         <= 1'b0;
            valid_q        <= 1'b1;
            reactionTime_q <= cntValue;
          end else if (cntTerminal) begin
            state_q        <= S_TMO;
            busy_q         <= 1'b0;
            timeout_q      <= 1'b1;
            reactionTime_q <= TMO_VAL;
          end
        end
        S_OK, S_FALSE, S_TMO: begin
          if (bus.yellow) begin
            state_q      <= S_ARMED;
            busy_q       <= 1'b1;
            valid_q      <= 1'b0;
            falseStart_q <= 1'b0;
            timeout_q    <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
          valid_q      <= 1'b0;
          falseStart_q <= 1'b0;
          timeout_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.valid         = valid_q;
  assign bus.false_start   = falseStart_q;
  assign bus.timeout       = timeout_q;
  assign bus.reaction_time = reactionTime_q;

`ifdef RACE_BEST_TIME_EN
  logic             okEntry_d;
  logic [CNT_W-1:0] okValue_d;
  logic [CNT_W-1:0] bestTime_q;

  // Detect the edge that enters OK and the reaction value it will latch.
  always_comb begin
    okEntry_d = ((state_q == S_ARMED) && bus.green && bus.go) ||
                ((state_q == S_TIMING) && bus.go);
    okValue_d = (state_q == S_TIMING) ? cntValue : '0;
  end

  // Best valid reaction since reset; only a strictly faster launch replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bestTime_q <= '1;
    end else if (okEntry_d && (okValue_d < bestTime_q)) begin
      bestTime_q <= okValue_d;
    end
  end

  assign bus.best_time = bestTime_q;
`else
  assign bus.best_time = '1;
`endif

endmodule

// File: tb/tb_race_reaction_timer.sv
// Scoreboard testbench for race_reaction_timer: stimulus pushes expected
// results, a monitor pops and compares whenever a result flag rises.
module tb_race_reaction_timer;
  import race_pkg::*;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;

  localparam logic [1:0] K_VALID = 2'd1;
  localparam logic [1:0] K_FALSE = 2'd2;
  localparam logic [1:0] K_TMO   = 2'd3;

  typedef struct {
    logic [1:0]       kind;
    logic [CNT_W-1:0] rt;
    logic [CNT_W-1:0] best;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  exp_t             expQ[$];
  int               testsRun    = 0;
  int               testsFailed = 0;
  logic [CNT_W-1:0] modelBest   = '1;

  race_reaction_timer_if #(.CNT_W(CNT_W)) bus ();

  race_reaction_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 100 MHz style free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input lamp_t lamps, input logic goVal, input int cycles);
    {bus.red, bus.yellow, bus.green} = lamps;
    bus.go = goVal;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic expectResult(input logic [1:0] kind, input logic [CNT_W-1:0] rt);
    exp_t e;
`ifdef RACE_BEST_TIME_EN
    if (kind == K_VALID && rt < modelBest) modelBest = rt;
`endif
    e.kind = kind;
    e.rt   = rt;
    e.best = modelBest;
    expQ.push_back(e);
  endtask

  // One complete race ending in a valid launch with the given reaction (>= 1).
  task automatic runRace(input int react);
    applyStimulus(LAMP_YELLOW, 1'b0, 1);
    checkOutput("flagsClearedOnYellow",
                {29'd0, bus.valid, bus.false_start, bus.timeout}, 32'd0);
    applyStimulus(LAMP_YELLOW, 1'b0, 2);
    applyStimulus(LAMP_DARK, 1'b0, 1);
    expectResult(K_VALID, CNT_W'(react));
    applyStimulus(LAMP_GREEN, 1'b0, 1);
    if (react > 1) applyStimulus(LAMP_GREEN, 1'b0, react - 1);
    applyStimulus(LAMP_GREEN, 1'b1, 1);
    applyStimulus(LAMP_DARK, 1'b0, 3);
  endtask

  // Monitor: on each rising result flag compare against the scoreboard head.
  initial begin : monitor
    logic       prevFlag;
    logic       curFlag;
    logic [1:0] gotKind;
    exp_t       e;
    prevFlag = 1'b0;
    forever begin
      @(negedge clk);
      curFlag = bus.valid | bus.false_start | bus.timeout;
      if (curFlag && !prevFlag) begin
        gotKind = bus.valid ? K_VALID : (bus.false_start ? K_FALSE : K_TMO);
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpectedResult: got kind %0d, expected no result", gotKind);
        end else begin
          e = expQ.pop_front();
          checkOutput("resultKind", {30'd0, gotKind}, {30'd0, e.kind});
          checkOutput("resultOneHot",
                      $countones({bus.valid, bus.false_start, bus.timeout}), 32'd1);
          checkOutput("reactionTime", {24'd0, bus.reaction_time}, {24'd0, e.rt});
          checkOutput("bestTime", {24'd0, bus.best_time}, {24'd0, e.best});
          checkOutput("busyLowWithResult", {31'd0, bus.busy}, 32'd0);
        end
      end
      prevFlag = curFlag;
    end
  end

  // Watchdog so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed race scenarios.
  initial begin : stimulus
    rst = 1'b1;
    {bus.red, bus.yellow, bus.green} = LAMP_DARK;
    bus.go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("resetFlags", {29'd0, bus.valid, bus.false_start, bus.timeout}, 32'd0);
    checkOutput("resetReactionTime", {24'd0, bus.reaction_time}, 32'd0);
    checkOutput("resetBestTime", {24'd0, bus.best_time}, 32'd255);
    rst = 1'b0;
    applyStimulus(LAMP_DARK, 1'b0, 1);

    // Normal launch, reaction 5.
    applyStimulus(LAMP_RED, 1'b0, 3);
    applyStimulus(LAMP_DARK, 1'b0, 1);
    runRace(5);
    applyStimulus(LAMP_DARK, 1'b0, 4);
    checkOutput("validHolds", {31'd0, bus.valid}, 32'd1);

    // False start: go on the last yellow cycle, later green ignored.
    applyStimulus(LAMP_YELLOW, 1'b0, 2);
    expectResult(K_FALSE, '0);
    applyStimulus(LAMP_YELLOW, 1'b1, 1);
    applyStimulus(LAMP_DARK, 1'b0, 1);
    applyStimulus(LAMP_GREEN, 1'b0, 3);
    checkOutput("falseStartHolds", {31'd0, bus.false_start}, 32'd1);
    checkOutput("falseStartNoValid", {31'd0, bus.valid}, 32'd0);
    checkOutput("falseStartRt", {24'd0, bus.reaction_time}, 32'd0);
    applyStimulus(LAMP_DARK, 1'b0, 1);

    // Timeout after TIMEOUT cycles with no go; green drops partway through.
    applyStimulus(LAMP_YELLOW, 1'b0, 3);
    applyStimulus(LAMP_DARK, 1'b0, 1);
    expectResult(K_TMO, CNT_W'(TIMEOUT));
    applyStimulus(LAMP_GREEN, 1'b0, 3);
    applyStimulus(LAMP_DARK, 1'b0, TIMEOUT + 3);
    checkOutput("timeoutHolds", {31'd0, bus.timeout}, 32'd1);

    // go exactly when the counter reaches TIMEOUT wins over timeout.
    applyStimulus(LAMP_YELLOW, 1'b0, 3);
    applyStimulus(LAMP_DARK, 1'b0, 1);
    expectResult(K_VALID, CNT_W'(TIMEOUT));
    applyStimulus(LAMP_GREEN, 1'b0, TIMEOUT);
    applyStimulus(LAMP_GREEN, 1'b1, 1);
    applyStimulus(LAMP_DARK, 1'b0, 3);

    // go and green sampled on the same edge: reaction 0.
    applyStimulus(LAMP_YELLOW, 1'b0, 3);
    applyStimulus(LAMP_DARK, 1'b0, 1);
    expectResult(K_VALID, '0);
    applyStimulus(LAMP_GREEN, 1'b1, 1);
    applyStimulus(LAMP_DARK, 1'b0, 3);

    // Reset in TIMING at counter 50 aborts immediately.
    applyStimulus(LAMP_YELLOW, 1'b0, 3);
    applyStimulus(LAMP_DARK, 1'b0, 1);
    applyStimulus(LAMP_GREEN, 1'b0, 50);
    checkOutput("busyInTiming", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abortBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("abortFlags", {29'd0, bus.valid, bus.false_start, bus.timeout}, 32'd0);
    checkOutput("abortBestTime", {24'd0, bus.best_time}, 32'd255);
    modelBest = '1;
    #2;
    rst = 1'b0;
    applyStimulus(LAMP_GREEN, 1'b0, 5);
    checkOutput("greenWithoutYellowIdle", {31'd0, bus.busy}, 32'd0);
    applyStimulus(LAMP_DARK, 1'b0, 2);

    // go during red only is ignored; then races of 9, 4, 12.
    applyStimulus(LAMP_RED, 1'b1, 3);
    applyStimulus(LAMP_RED, 1'b0, 1);
    checkOutput("redGoIgnoredBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("redGoIgnoredFlag", {31'd0, bus.false_start}, 32'd0);
    applyStimulus(LAMP_DARK, 1'b0, 1);
    runRace(9);
    runRace(4);
    runRace(12);

    applyStimulus(LAMP_DARK, 1'b0, 3);
    checkOutput("scoreboardDrained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/race_reaction_timer.md
Name: race_reaction_timer

Overview:
- Receive side of the race light tree. Watches the red/yellow/green lamp lines and the driver's go (pedal) input.
- Judges each start as a valid launch, a false start, or a timeout. For valid launches it measures reaction time in clock cycles from green onset.
- Sits beside the light controller in the race-timing subsystem. Results feed the scoreboard/display logic.

Parameters:
- CNT_W, 8: width of the reaction counter and of reaction_time / best_time.
- TIMEOUT, 200: cycles after green with no go before the start is judged a timeout. Must satisfy 1 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all sampling on posedge.
- rst  in  1  reset, asynchronous, active-high.
- red  in  1  red lamp from light controller.
- yellow  in  1  yellow lamp.
- green  in  1  green lamp.
- go  in  1  driver pedal, level, active-high, synchronous to clk.
- busy  out  1  high in ARMED or TIMING.
- valid  out  1  high while holding a valid launch result.
- false_start  out  1  high while holding a false-start result.
- timeout  out  1  high while holding a timeout result.
- reaction_time  out  CNT_W  latched reaction cycles; meaningful when valid or timeout.
- best_time  out  CNT_W  best valid reaction since reset (see Optional Feature).

Behaviour:
- Reset: state IDLE, counter 0. busy, valid, false_start and timeout are 0. reaction_time is 0. best_time is all-ones.
- Reset mid-race aborts immediately to IDLE with no result.
- All outputs are registered. Lamps and go are sampled on posedge; no synchronisers (same clock domain).
- States:
  - IDLE: waits for yellow==1; then goes to ARMED. red and green are ignored here; a green seen without a preceding yellow never arms.
  - ARMED: if go==1 and green==0, go to FALSE. Else if green==1 and go==1 on the same edge, go to OK with reaction_time=0. Else if green==1, go to TIMING with counter loaded to 1. Otherwise stay. The dark gaps between lamps stay in ARMED.
  - TIMING: counter = cycles since green first sampled high. If go==1, go to OK with reaction_time=counter; this takes priority over timeout on the same edge. Else if counter==TIMEOUT, go to TMO with reaction_time=TIMEOUT. Else increment the counter. The counter never wraps. green dropping during TIMING has no effect.
  - OK / FALSE / TMO: the matching flag is held high (valid / false_start / timeout) and reaction_time is held; for FALSE, reaction_time=0. On yellow==1, go to ARMED and clear all flags on that edge (new race). Nothing else leaves these states except rst.
- Pedal pressed during the red stage (before yellow) is ignored; only go during ARMED counts as a false start.
- A go held high across arming produces a false start on the first ARMED cycle.
- Exactly one of valid, false_start or timeout is high at a time; all are low in IDLE, ARMED and TIMING.
- Latency: a result flag rises on the first posedge after the deciding edge (registered state).

Optional Feature:
- Macro RACE_BEST_TIME_EN.
- Defined: best_time register, reset to all-ones. On entry to OK, if reaction_time < best_time, best_time is updated. False starts and timeouts never update it. It is cleared only by rst.
- Undefined: no register; best_time is tied to all-ones.

Decomposition:
- Shared package race_pkg holds:
  - state encodings (IDLE, ARMED, TIMING, OK, FALSE, TMO) as localparams;
  - lamp-vector encoding {red, yellow, green}, shared with the light controller;
  - default CNT_W/TIMEOUT constants.
- One sub-module, race_reaction_counter: CNT_W-bit counter with load-to-1, enable, saturation at TIMEOUT, and a terminal flag.
- FSM and result registers stay in the top.

Test Plan:
- Lamp sequence red x3, dark, yellow x3, dark, green; go rises 5 cycles after green is sampled -> valid=1, reaction_time=5, busy=0; best_time=5 with RACE_BEST_TIME_EN.
- go high during yellow -> false_start=1 next cycle, reaction_time=0, valid=0; later green is ignored and the flag holds.
- Green with go never asserted, TIMEOUT=200 -> timeout=1 after counter reaches 200, reaction_time=200; go at exactly counter 200 instead -> valid, reaction_time=200.
- go and green first sampled high on the same edge -> valid=1, reaction_time=0. Separately, go asserted during red only, then released before yellow -> no false start, and the race proceeds normally.
- Two races with reactions 9 then 4, then a third with 12 -> best_time 9, then 4, then stays 4 (macro on); stays 8'hFF with macro off. Each yellow clears the previous flags.
- rst asserted in TIMING at counter 50 -> all flags and busy are 0 immediately (asynchronous); a subsequent green without yellow -> stays IDLE.
